// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers ROM words into the IR, and halts on HALT_WORD.
// Optional FETCH_PERF_EN adds saturating fetch_count / flush_count outputs.
module fetch_unit #(
    parameter int                 ADDR_W    = 8,
    parameter int                 DATA_W    = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  NOP_WORD  = '0,
    parameter logic [DATA_W-1:0]  HALT_WORD = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       fetch_count,
    output logic [15:0]       flush_count
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
    logic                ir_valid_q, ir_valid_d;
    logic                fetch_fire;
    logic                flush_fire;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        fetch_fire = 1'b0;
        flush_fire = 1'b0;

        if (redirect_valid) begin
            // Redirect outranks stall and HALT; the IR gets a bubble while the target is fetched.
            pc_d       = redirect_addr;
            ir_d       = NOP_WORD;
            ir_valid_d = 1'b0;
            state_d    = ST_RUN;
            flush_fire = 1'b1;
        end else if (state_q == ST_HALT) begin
            ir_valid_d = 1'b0;
        end else if (!stall) begin
            ir_d       = rom_data;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            fetch_fire = 1'b1;
            if (rom_data == HALT_WORD) begin
                state_d = ST_HALT;
            end else begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            ir_q       <= NOP_WORD;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign pc_out   = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = (state_q == ST_HALT);

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count_q, fetch_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (fetch_fire && fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
        if (flush_fire && flush_count_q != 16'hFFFF) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`else
    logic unused_fire;
    assign unused_fire = fetch_fire | flush_fire;
`endif

endmodule
